tile_map_ram: RTL and testbench
===============================

TILE_MAP_RAM -- requirements
Module: tile_map_ram

Interface
REQ-001 The block SHALL have parameter ROWS, default 40, meaning map height in tiles.
REQ-002 The block SHALL have parameter COLS, default 40, meaning map width in tiles.
REQ-003 The block SHALL have parameter TILE_W, default 8, meaning tile index width.
REQ-004 The block SHALL have parameters FLOOR_IDX=10, BRICK_IDX=9 and WALL_IDX=8, meaning the tile codes.
REQ-005 The block SHALL have parameter MAX_R, default 7, meaning maximum blast radius.
REQ-006 The block SHALL have port Clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port Reset, input, 1 bit, a synchronous active-high reset.
REQ-008 The block SHALL have ports rd_en (input, 1), rd_row (input, clog2(ROWS)) and rd_col (input, clog2(COLS)), forming the renderer read request.
REQ-009 The block SHALL have ports rd_data (output, TILE_W) and rd_valid (output, 1), forming the read response.
REQ-010 The block SHALL have ports wr_en (input, 1), wr_row, wr_col and wr_data (input, TILE_W), forming the game-logic write.
REQ-011 The block SHALL have ports blast_start (input, 1), blast_row, blast_col and blast_radius (input, clog2(MAX_R+1)), forming the blast command.
REQ-012 The block SHALL have outputs busy (1), init_done (1), blast_done (1), cleared (clog2(4*MAX_R+1)) and wr_err (1).

Function
REQ-013 The block SHALL hold ROWS*COLS tiles of TILE_W bits, with one internal write path and one independent read path.
REQ-014 The FSM SHALL have states INIT, IDLE, CENTER, UP, DOWN, LEFT, RIGHT and DONE.
REQ-015 In INIT the block SHALL write one cell per cycle in row-major order: WALL_IDX on the border or where row and col are both even, FLOOR_IDX otherwise.
REQ-016 INIT SHALL take exactly ROWS*COLS cycles, then the block SHALL enter IDLE and set init_done high, where it stays until Reset.
REQ-017 A read with rd_en=1 SHALL return rd_data one cycle later with rd_valid=1; with rd_en=0 the next cycle SHALL have rd_valid=0.
REQ-018 A read request during INIT SHALL produce rd_valid=0.
REQ-019 A read from a cell written in the same cycle SHALL return the old value.
REQ-020 rd_row>=ROWS or rd_col>=COLS SHALL return WALL_IDX with rd_valid=1.
REQ-021 wr_en in IDLE with in-range coordinates SHALL update the cell on that edge.
REQ-022 wr_en in any other state, or with out-of-range coordinates, SHALL be dropped and wr_err SHALL pulse high one cycle later.
REQ-023 blast_start in IDLE SHALL latch the coordinates and the radius clamped to MAX_R, clear cleared to 0, raise busy on the next cycle and enter CENTER.
REQ-024 blast_start outside IDLE SHALL be ignored.
REQ-025 If blast_start and wr_en occur in the same IDLE cycle, the write SHALL be performed and the blast SHALL also start.
REQ-026 CENTER SHALL take 1 cycle and leave the cell unchanged.
REQ-027 Each direction state SHALL examine one cell per cycle at distance k=1..radius, in the order UP (row-1), DOWN, LEFT (col-1), RIGHT.
REQ-028 For each examined cell: out of range or WALL_IDX ends the direction with the cell unchanged.
REQ-029 For each examined cell: BRICK_IDX is written to FLOOR_IDX, cleared is incremented and the direction ends.
REQ-030 For each examined cell: any other value continues the direction; reaching k=radius ends the direction.
REQ-031 A radius of 0 SHALL go CENTER then DONE.
REQ-032 DONE SHALL last 1 cycle, pulse blast_done, drop busy on the following cycle and return to IDLE; cleared SHALL hold until the next blast_start.
REQ-033 Blast latency SHALL be 2 + (cells examined) cycles, with at most 2+4*radius.
REQ-034 busy SHALL be high throughout INIT and from CENTER through DONE.

Reset
REQ-035 Reset SHALL have priority over all other inputs, including mid-INIT and mid-blast.
REQ-036 On Reset the FSM SHALL enter INIT at cell 0 and abort any blast.
REQ-037 On Reset, init_done=0, busy=1, rd_valid=0, rd_data=0, blast_done=0, cleared=0 and wr_err=0.
REQ-038 The full map SHALL be re-initialised after Reset.

Verification
REQ-039 The bench SHALL cover: Reset for 1 cycle, then 1600 cycles -> init_done rises at cycle 1600; reads give (0,5)=8, (2,2)=8, (1,1)=10 and (3,4)=10.
REQ-040 The bench SHALL cover: write (1,3)=9, then read (1,3) -> rd_data=9 one cycle after rd_en; a same-cycle read returns 10.
REQ-041 The bench SHALL cover: bricks at (1,5) and (1,7), blast at (1,3) radius 5 -> (1,5) becomes 10, (1,7) stays 9, cleared=1; UP stops at the border; blast_done pulses once.
REQ-042 The bench SHALL cover: wr_en and a second blast_start while busy -> wr_err pulses, the map is unchanged and the second blast is ignored.
REQ-043 The bench SHALL cover: Reset asserted mid-blast -> busy stays high, init_done=0 and the map is restored to the INIT pattern after 1600 cycles.
REQ-044 The bench SHALL cover: a read at (40,0) -> rd_data=8 with rd_valid=1; blast_radius=0 -> blast_done 2 cycles after start and cleared=0.

Source files
------------

// File: rtl/tile_map_ram.sv
// Tile map storage for a bomb-style game: power-up pattern fill, renderer read port,
// game-logic write port and a cross-shaped blast walker that turns bricks into floor.
module tile_map_ram #(
   parameter int unsigned ROWS      = 40,
   parameter int unsigned COLS      = 40,
   parameter int unsigned TILE_W    = 8,
   parameter int unsigned FLOOR_IDX = 10,
   parameter int unsigned BRICK_IDX = 9,
   parameter int unsigned WALL_IDX  = 8,
   parameter int unsigned MAX_R     = 7
) (
   input  logic                           Clk,
   input  logic                           Reset,
   input  logic                           rd_en,
   input  logic [$clog2(ROWS)-1:0]        rd_row,
   input  logic [$clog2(COLS)-1:0]        rd_col,
   output logic [TILE_W-1:0]              rd_data,
   output logic                           rd_valid,
   input  logic                           wr_en,
   input  logic [$clog2(ROWS)-1:0]        wr_row,
   input  logic [$clog2(COLS)-1:0]        wr_col,
   input  logic [TILE_W-1:0]              wr_data,
   input  logic                           blast_start,
   input  logic [$clog2(ROWS)-1:0]        blast_row,
   input  logic [$clog2(COLS)-1:0]        blast_col,
   input  logic [$clog2(MAX_R+1)-1:0]     blast_radius,
   output logic                           busy,
   output logic                           init_done,
   output logic                           blast_done,
   output logic [$clog2(4*MAX_R+1)-1:0]   cleared,
   output logic                           wr_err
);

   localparam int unsigned RW    = $clog2(ROWS);
   localparam int unsigned CW    = $clog2(COLS);
   localparam int unsigned RADW  = $clog2(MAX_R + 1);
   localparam int unsigned CLW   = $clog2(4 * MAX_R + 1);
   localparam int unsigned CELLS = ROWS * COLS;
   localparam int unsigned AW    = $clog2(CELLS);

   localparam logic [TILE_W-1:0] FLOOR_T = TILE_W'(FLOOR_IDX);
   localparam logic [TILE_W-1:0] BRICK_T = TILE_W'(BRICK_IDX);
   localparam logic [TILE_W-1:0] WALL_T  = TILE_W'(WALL_IDX);

   typedef enum logic [2:0] {INIT, IDLE, CENTER, UP, DOWN, LEFT, RIGHT, DONE} state_t;

   logic [TILE_W-1:0] mem [CELLS];

   state_t          state;
   logic [RW-1:0]   ini_row, b_row;
   logic [CW-1:0]   ini_col, b_col;
   logic [RADW-1:0] b_rad, k, rad_clamp;

   logic            rd_oob, wr_oob, ini_wall;
   logic [AW-1:0]   rd_addr, wr_addr, ini_addr;

   logic [31:0]       ex_row, ex_col;
   logic              ex_oob;
   logic [AW-1:0]     ex_addr;
   logic [TILE_W-1:0] ex_tile;
   logic              ex_brick, ex_stop;

   logic              we;
   logic [AW-1:0]     waddr;
   logic [TILE_W-1:0] wdata;

   // Address decode for the three external/initialisation access paths
   always_comb begin
      rd_oob    = (32'(rd_row) >= ROWS) || (32'(rd_col) >= COLS);
      wr_oob    = (32'(wr_row) >= ROWS) || (32'(wr_col) >= COLS);
      rd_addr   = AW'(32'(rd_row) * COLS + 32'(rd_col));
      wr_addr   = AW'(32'(wr_row) * COLS + 32'(wr_col));
      ini_addr  = AW'(32'(ini_row) * COLS + 32'(ini_col));
      ini_wall  = (ini_row == '0) || (32'(ini_row) == ROWS - 1) ||
                  (ini_col == '0) || (32'(ini_col) == COLS - 1) ||
                  (!ini_row[0] && !ini_col[0]);
      rad_clamp = (32'(blast_radius) > MAX_R) ? RADW'(MAX_R) : blast_radius;
   end

   // Cell under examination; UP/LEFT underflow wraps to a huge value and reads as out of range
   always_comb begin
      ex_row = 32'(b_row);
      ex_col = 32'(b_col);
      case (state)
         UP:      ex_row = 32'(b_row) - 32'(k);
         DOWN:    ex_row = 32'(b_row) + 32'(k);
         LEFT:    ex_col = 32'(b_col) - 32'(k);
         RIGHT:   ex_col = 32'(b_col) + 32'(k);
         default: ;
      endcase
      ex_oob   = (ex_row >= ROWS) || (ex_col >= COLS);
      ex_addr  = AW'(ex_row * COLS + ex_col);
      ex_tile  = mem[ex_addr];
      ex_brick = !ex_oob && (ex_tile == BRICK_T);
      ex_stop  = ex_oob || (ex_tile == WALL_T) || (ex_tile == BRICK_T) || (k == b_rad);
   end

   // Single write port shared by fill, game writes and brick clearing
   always_comb begin
      we    = 1'b0;
      waddr = ini_addr;
      wdata = ini_wall ? WALL_T : FLOOR_T;
      if (!Reset) begin
         case (state)
            INIT: we = 1'b1;
            IDLE: begin
               we    = wr_en && !wr_oob;
               waddr = wr_addr;
               wdata = wr_data;
            end
            UP, DOWN, LEFT, RIGHT: begin
               we    = ex_brick;
               waddr = ex_addr;
               wdata = FLOOR_T;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state      <= INIT;
         ini_row    <= '0;
         ini_col    <= '0;
         b_row      <= '0;
         b_col      <= '0;
         b_rad      <= '0;
         k          <= '0;
         init_done  <= 1'b0;
         busy       <= 1'b1;
         rd_valid   <= 1'b0;
         rd_data    <= '0;
         blast_done <= 1'b0;
         cleared    <= '0;
         wr_err     <= 1'b0;
      end else begin
         blast_done <= 1'b0;
         rd_valid   <= rd_en && (state != INIT);
         if (rd_en && (state != INIT)) rd_data <= rd_oob ? WALL_T : mem[rd_addr];
         wr_err     <= wr_en && ((state != IDLE) || wr_oob);

         case (state)
            INIT: begin
               if (ini_col == CW'(COLS - 1)) begin
                  ini_col <= '0;
                  if (ini_row == RW'(ROWS - 1)) begin
                     state     <= IDLE;
                     init_done <= 1'b1;
                     busy      <= 1'b0;
                  end else begin
                     ini_row <= ini_row + 1'b1;
                  end
               end else begin
                  ini_col <= ini_col + 1'b1;
               end
            end
            IDLE: begin
               if (blast_start) begin
                  b_row   <= blast_row;
                  b_col   <= blast_col;
                  b_rad   <= rad_clamp;
                  cleared <= '0;
                  busy    <= 1'b1;
                  state   <= CENTER;
               end
            end
            CENTER: begin
               k     <= RADW'(1);
               state <= (b_rad == '0) ? DONE : UP;
            end
            UP, DOWN, LEFT, RIGHT: begin
               if (ex_brick) cleared <= cleared + CLW'(1);
               if (ex_stop) begin
                  k <= RADW'(1);
                  case (state)
                     UP:      state <= DOWN;
                     DOWN:    state <= LEFT;
                     LEFT:    state <= RIGHT;
                     default: state <= DONE;
                  endcase
               end else begin
                  k <= k + 1'b1;
               end
            end
            DONE: begin
               blast_done <= 1'b1;
               busy       <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tile_map_ram.sv
// Bench for tile_map_ram: directed scenarios plus random traffic against an array map model.
module tb_tile_map_ram;

   localparam int ROWS = 40;
   localparam int COLS = 40;

   logic       Clk, Reset;
   logic       rd_en;
   logic [5:0] rd_row, rd_col;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       wr_en;
   logic [5:0] wr_row, wr_col;
   logic [7:0] wr_data;
   logic       blast_start;
   logic [5:0] blast_row, blast_col;
   logic [2:0] blast_radius;
   logic       busy, init_done, blast_done, wr_err;
   logic [4:0] cleared;

   int total = 0;
   int bad   = 0;
   int mdl [ROWS][COLS];

   tile_map_ram dut (
      .Clk(Clk), .Reset(Reset),
      .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col),
      .rd_data(rd_data), .rd_valid(rd_valid),
      .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
      .blast_start(blast_start), .blast_row(blast_row), .blast_col(blast_col),
      .blast_radius(blast_radius),
      .busy(busy), .init_done(init_done), .blast_done(blast_done),
      .cleared(cleared), .wr_err(wr_err)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish (observed=timeout required=finish)");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic model_reset;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            mdl[r][c] = (r == 0 || r == ROWS-1 || c == 0 || c == COLS-1 ||
                         (r % 2 == 0 && c % 2 == 0)) ? 8 : 10;
   endtask

   function automatic int exp_tile(input int r, input int c);
      if (r >= ROWS || c >= COLS) return 8;
      return mdl[r][c];
   endfunction

   // Cross-shaped blast: walk each arm until edge, wall, brick or radius
   task automatic model_blast(input int br, input int bc, input int rad,
                              output int clr, output int exam);
      int dr [4] = '{-1, 1, 0, 0};
      int dc [4] = '{0, 0, -1, 1};
      int r, c;
      clr  = 0;
      exam = 0;
      if (rad > 7) rad = 7;
      for (int d = 0; d < 4; d++) begin
         for (int kk = 1; kk <= rad; kk++) begin
            r = br + dr[d] * kk;
            c = bc + dc[d] * kk;
            exam++;
            if (r < 0 || r >= ROWS || c < 0 || c >= COLS) break;
            if (mdl[r][c] == 8) break;
            if (mdl[r][c] == 9) begin
               mdl[r][c] = 10;
               clr++;
               break;
            end
         end
      end
   endtask

   task automatic run_init(input string tag);
      rd_en  = 1'b1;
      rd_row = 6'd1;
      rd_col = 6'd1;
      for (int i = 1; i <= ROWS*COLS; i++) begin
         tick;
         if (i == 3) begin
            chk({tag, "_rd_in_init"}, 32'(rd_valid), 0);
            rd_en = 1'b0;
         end
         if (i == 800) chk({tag, "_busy_init"}, 32'(busy), 1);
         if (i == ROWS*COLS - 1) chk({tag, "_init_early"}, 32'(init_done), 0);
         if (i == ROWS*COLS) begin
            chk({tag, "_init_done"}, 32'(init_done), 1);
            chk({tag, "_busy_idle"}, 32'(busy), 0);
         end
      end
      model_reset();
   endtask

   task automatic do_read(input int r, input int c, input string tag);
      rd_en  = 1'b1;
      rd_row = 6'(r);
      rd_col = 6'(c);
      tick;
      rd_en = 1'b0;
      chk({tag, "_valid"}, 32'(rd_valid), 1);
      chk({tag, "_data"}, 32'(rd_data), 32'(exp_tile(r, c)));
   endtask

   task automatic do_write(input int r, input int c, input int d, input string tag);
      bit oob;
      oob     = (r >= ROWS || c >= COLS);
      wr_en   = 1'b1;
      wr_row  = 6'(r);
      wr_col  = 6'(c);
      wr_data = 8'(d);
      tick;
      wr_en = 1'b0;
      chk({tag, "_wr_err"}, 32'(wr_err), 32'(oob));
      if (!oob) mdl[r][c] = d;
   endtask

   task automatic do_blast(input int r, input int c, input int rad, input bit interfere,
                           input string tag);
      int clr, exam, lat;
      model_blast(r, c, rad, clr, exam);
      blast_row    = 6'(r);
      blast_col    = 6'(c);
      blast_radius = 3'(rad);
      blast_start  = 1'b1;
      tick;
      blast_start = 1'b0;
      chk({tag, "_busy_start"}, 32'(busy), 1);
      chk({tag, "_clr_zero"}, 32'(cleared), 0);
      lat = 0;
      while (blast_done !== 1'b1 && lat < 100) begin
         if (interfere && lat == 0) begin
            wr_en        = 1'b1;
            wr_row       = 6'd2;
            wr_col       = 6'd3;
            wr_data      = 8'd9;
            blast_start  = 1'b1;
            blast_row    = 6'd1;
            blast_col    = 6'd1;
            blast_radius = 3'd7;
         end
         tick;
         lat++;
         if (interfere && lat == 1) begin
            wr_en       = 1'b0;
            blast_start = 1'b0;
            chk({tag, "_wr_err_busy"}, 32'(wr_err), 1);
         end
      end
      chk({tag, "_latency"}, 32'(lat), 32'(2 + exam));
      chk({tag, "_done"}, 32'(blast_done), 1);
      chk({tag, "_cleared"}, 32'(cleared), 32'(clr));
      chk({tag, "_busy_end"}, 32'(busy), 0);
      tick;
      chk({tag, "_done_pulse"}, 32'(blast_done), 0);
      chk({tag, "_clr_hold"}, 32'(cleared), 32'(clr));
      if (interfere) begin
         tick;
         chk({tag, "_second_ignored"}, 32'(busy), 0);
         do_read(2, 3, {tag, "_map_kept"});
      end
   endtask

   initial begin
      int op, r, c, d;
      Reset = 1'b1; rd_en = 1'b0; rd_row = '0; rd_col = '0;
      wr_en = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0;
      blast_start = 1'b0; blast_row = '0; blast_col = '0; blast_radius = '0;

      tick;
      chk("rst_busy", 32'(busy), 1);
      chk("rst_init_done", 32'(init_done), 0);
      chk("rst_rd_valid", 32'(rd_valid), 0);
      chk("rst_rd_data", 32'(rd_data), 0);
      chk("rst_blast_done", 32'(blast_done), 0);
      chk("rst_cleared", 32'(cleared), 0);
      chk("rst_wr_err", 32'(wr_err), 0);
      Reset = 1'b0;
      run_init("init1");

      do_read(0, 5, "rd_0_5");
      do_read(2, 2, "rd_2_2");
      do_read(1, 1, "rd_1_1");
      do_read(3, 4, "rd_3_4");
      tick;
      chk("rd_idle_valid", 32'(rd_valid), 0);

      // Write and read the same cell on one edge: read must see the old tile
      wr_en = 1'b1; wr_row = 6'd1; wr_col = 6'd3; wr_data = 8'd9;
      rd_en = 1'b1; rd_row = 6'd1; rd_col = 6'd3;
      tick;
      wr_en = 1'b0; rd_en = 1'b0;
      chk("same_cyc_valid", 32'(rd_valid), 1);
      chk("same_cyc_old", 32'(rd_data), 10);
      chk("same_cyc_wr_err", 32'(wr_err), 0);
      mdl[1][3] = 9;
      do_read(1, 3, "rd_after_wr");

      do_write(1, 5, 9, "brick_1_5");
      do_write(1, 7, 9, "brick_1_7");
      do_blast(1, 3, 5, 1'b0, "blast_a");
      do_read(1, 5, "blast_a_1_5");
      do_read(1, 7, "blast_a_1_7");

      do_blast(5, 5, 7, 1'b1, "blast_busy");
      do_write(40, 3, 9, "wr_oob");

      do_read(40, 0, "rd_oob");
      do_blast(10, 10, 0, 1'b0, "blast_r0");

      for (int n = 0; n < 80; n++) begin
         op = int'($urandom_range(0, 2));
         r  = int'($urandom_range(0, 41));
         c  = int'($urandom_range(0, 41));
         if (op == 0) begin
            do_read(r, c, "rnd_rd");
         end else if (op == 1) begin
            d = int'($urandom_range(0, 3));
            d = (d < 2) ? 9 : (d == 2) ? 10 : int'($urandom_range(0, 255));
            do_write(r, c, d, "rnd_wr");
         end else begin
            do_blast(r % ROWS, c % COLS, int'($urandom_range(0, 7)), 1'b0, "rnd_blast");
         end
      end
      for (int rr = 0; rr < ROWS; rr++)
         for (int cc = 0; cc < COLS; cc++)
            do_read(rr, cc, "sweep");

      // Abort a blast with reset and confirm the map is rebuilt
      do_write(6, 9, 9, "pre_rst_brick");
      blast_row = 6'd6; blast_col = 6'd5; blast_radius = 3'd7;
      blast_start = 1'b1;
      tick;
      blast_start = 1'b0;
      tick;
      tick;
      Reset = 1'b1;
      tick;
      chk("midblast_busy", 32'(busy), 1);
      chk("midblast_init_done", 32'(init_done), 0);
      chk("midblast_blast_done", 32'(blast_done), 0);
      chk("midblast_cleared", 32'(cleared), 0);
      Reset = 1'b0;
      run_init("init2");
      do_read(1, 3, "reinit_1_3");
      do_read(1, 7, "reinit_1_7");
      do_read(6, 9, "reinit_6_9");
      for (int n = 0; n < 20; n++)
         do_read(int'($urandom_range(0, 39)), int'($urandom_range(0, 39)), "reinit_rnd");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
